// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared constants for the PS/2 keyboard receiver: FSM state
//               encoding, scan-code prefixes and FIFO entry width.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Frame FSM state encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    // Scan-code prefixes folded into the ext/brk flags
    localparam logic [7:0] c_PS2_EXT = 8'hE0;
    localparam logic [7:0] c_PS2_BRK = 8'hF0;

    // FIFO entry layout: {ext, brk, code[7:0]}
    localparam int c_FIFO_W = 10;

endpackage
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : Synchronous FIFO holding decoded {ext, brk, code} entries.
//               A write while full is accepted only if a read happens in the
//               same cycle; reads while empty are ignored. Storage is not
//               reset, only the pointers are.
// Ports       : clk, rst (async, active-low)
//               i_wr_en / i_wr_data  - write request and entry
//               i_rd_en              - pop the head entry
//               o_rd_data            - head entry (valid while !o_empty)
//               o_full / o_empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int           c_AW  = $clog2(DEPTH);
    localparam logic [c_AW:0] c_ONE = (c_AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    assign w_rd_ok = i_rd_en & ~o_empty;
    // When full, a simultaneous pop frees the slot being written
    assign w_wr_ok = i_wr_en & (~o_full | w_rd_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_rx
// Description : System-clocked PS/2 keyboard receiver. Synchronises and
//               glitch-filters the PS/2 pins, frames 11-bit packets, checks
//               start/odd-parity/stop, folds E0/F0 prefixes into flags and
//               buffers {ext, brk, code} in an output FIFO.
// Ports       : clk, rst (async, active-low)
//               clk_kb, data_kb      - asynchronous PS/2 pins
//               out_code/ext/brk     - FIFO head, out_valid = FIFO not empty
//               out_ready            - pop when out_valid & out_ready
//               frame_err, overflow  - 1-cycle error pulses
//               err_cnt              - saturating error counter, only when
//                                      PS2_RX_ERRCNT_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_kb,
    input  logic       data_kb,
    output logic [7:0] out_code,
    output logic       out_ext,
    output logic       out_brk,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overflow
`ifdef PS2_RX_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int                c_FLT_W   = $clog2(FILTER_LEN);
    localparam logic [c_FLT_W-1:0] c_FLT_MAX = c_FLT_W'(FILTER_LEN - 1);
    localparam logic [c_FLT_W-1:0] c_FLT_ONE = c_FLT_W'(1);
    localparam int                c_TO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [c_TO_W-1:0]  c_TO_MAX  = c_TO_W'(TIMEOUT_CYC - 1);
    localparam logic [c_TO_W-1:0]  c_TO_ONE  = c_TO_W'(1);

    // ---------------- input synchronisers and glitch filter ----------------
    logic               r_clk_s1, r_clk_s2;
    logic               r_dat_s1, r_dat_s2;
    logic               r_clk_flt;
    logic [c_FLT_W-1:0] r_flt_cnt;
    logic               w_fall_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= clk_kb;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= data_kb;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered level flips only after FILTER_LEN consecutive samples
    // at the new level; any return to the old level restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_flt <= 1'b1;
            r_flt_cnt <= '0;
        end else if (r_clk_s2 != r_clk_flt) begin
            if (r_flt_cnt == c_FLT_MAX) begin
                r_clk_flt <= r_clk_s2;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + c_FLT_ONE;
            end
        end else begin
            r_flt_cnt <= '0;
        end
    end

    // High in the cycle just before the filtered clock drops
    assign w_fall_evt = r_clk_flt && !r_clk_s2 && (r_flt_cnt == c_FLT_MAX);

    // ---------------- frame FSM ----------------
    logic [1:0]        r_state;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_timeout;
    logic              r_good;
    logic [7:0]        r_byte;
    logic              r_frame_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (r_state == c_ST_IDLE || w_fall_evt) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + c_TO_ONE;
        end
    end

    assign w_timeout = (r_state != c_ST_IDLE) && !w_fall_evt && (r_to_cnt == c_TO_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_good      <= 1'b0;
            r_byte      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_good      <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_timeout) begin
                r_state     <= c_ST_IDLE;
                r_frame_err <= 1'b1;
            end else if (w_fall_evt) begin
                case (r_state)
                    c_ST_IDLE: begin
                        // A high data line here is not a start bit; ignore it
                        if (!r_dat_s2) begin
                            r_state   <= c_ST_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    c_ST_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) r_state <= c_ST_PARITY;
                    end
                    c_ST_PARITY: begin
                        r_parity <= r_dat_s2;
                        r_state  <= c_ST_STOP;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        if ((^{r_shift, r_parity}) && r_dat_s2) begin
                            r_good <= 1'b1;
                            r_byte <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- prefix decoder and FIFO ----------------
    logic                r_ext, r_brk;
    logic                r_overflow;
    logic                w_push, w_pop;
    logic                w_full, w_empty;
    logic [c_FIFO_W-1:0] w_rd_data;

    assign w_push = r_good && (r_byte != c_PS2_EXT) && (r_byte != c_PS2_BRK);
    assign w_pop  = out_ready & ~w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push & w_full & ~w_pop;
            if (r_good) begin
                if (r_byte == c_PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_byte == c_PS2_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    // Cleared even when the entry is dropped on overflow
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data ({r_ext, r_brk, r_byte}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Head is forced to zero while empty so outputs are defined out of reset
    assign out_valid = ~w_empty;
    assign out_code  = w_empty ? 8'h00 : w_rd_data[7:0];
    assign out_brk   = ~w_empty & w_rd_data[8];
    assign out_ext   = ~w_empty & w_rd_data[9];
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

`ifdef PS2_RX_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if ((r_frame_err || r_overflow) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_kbd_rx
// Description : Self-checking bench for ps2_kbd_rx. Stimulus tasks drive
//               PS/2 frames and queue the expected FIFO entries; a monitor
//               pops and compares whenever the DUT hands over an entry and
//               counts error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 600;
    localparam int FIFO_DEPTH  = 4;
    localparam int HALF        = 30;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       clk_kb    = 1'b1;
    logic       data_kb   = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] out_code;
    logic       out_ext;
    logic       out_brk;
    logic       out_valid;
    logic       frame_err;
    logic       overflow;
`ifdef PS2_RX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    ps2_kbd_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_kb    (clk_kb),
        .data_kb   (data_kb),
        .out_code  (out_code),
        .out_ext   (out_ext),
        .out_brk   (out_brk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overflow  (overflow)
`ifdef PS2_RX_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         err_seen = 0;
    int         ovf_seen = 0;
    int         exp_err  = 0;
    int         exp_ovf  = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pop on every accepted entry, count error pulses
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) err_seen++;
            if (overflow)  ovf_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_entry actual=%0h required=none",
                             {out_ext, out_brk, out_code});
                end else begin
                    exp_v = exp_q.pop_front();
                    check("fifo_entry", {22'd0, out_ext, out_brk, out_code}, {22'd0, exp_v});
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        data_kb = b;
        repeat (HALF) @(negedge clk);
        clk_kb = 1'b0;
        repeat (HALF) @(negedge clk);
        clk_kb = 1'b1;
    endtask

    // Full frame; optionally measures clk cycles from the stop-bit clock
    // fall to out_valid (2 sync + FILTER_LEN filter + FSM + FIFO write).
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop, input logic lat_chk);
        int  lat;
        bit  found;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ par_flip);
        data_kb = stop;
        repeat (HALF) @(negedge clk);
        clk_kb = 1'b0;
        lat    = 0;
        found  = 1'b0;
        repeat (HALF) begin
            @(posedge clk);
            #1;
            if (!found) lat++;
            if (out_valid) found = 1'b1;
        end
        if (lat_chk) check("latency", lat, FILTER_LEN + 3);
        @(negedge clk);
        clk_kb  = 1'b1;
        data_kb = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(b[i]);
        data_kb = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_code", out_code, 0);
        check("rst_flags", {out_ext, out_brk}, 0);
        check("rst_pulses", {frame_err, overflow}, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1: plain code with latency check
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
        wait_drain();
        check("t1_no_err", err_seen, exp_err);

        // 2: E0 F0 75 folds into one entry, flags cleared for next code
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        check("t2_prefix_no_push", out_valid, 0);
        exp_q.push_back({2'b11, 8'h75});
        send_frame(8'h75, 1'b0, 1'b1, 1'b0);
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        wait_drain();

        // 3: parity error
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        exp_err++;
        check("t3_parity_err", err_seen, exp_err);
        check("t3_empty", out_valid, 0);

        // 4: stop bit error
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        exp_err++;
        check("t4_stop_err", err_seen, exp_err);
        check("t4_empty", out_valid, 0);

        // 5: timeout after 4 bits, then a good frame
        send_partial(8'h32, 3);
        repeat (TIMEOUT_CYC + 50) @(negedge clk);
        exp_err++;
        check("t5_timeout_err", err_seen, exp_err);
        exp_q.push_back({2'b00, 8'h32});
        send_frame(8'h32, 1'b0, 1'b1, 1'b0);
        wait_drain();

        // 6: short glitch with data low must not start a frame
        data_kb = 1'b0;
        clk_kb  = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        clk_kb  = 1'b1;
        repeat (HALF) @(negedge clk);
        data_kb = 1'b1;
        repeat (HALF) @(negedge clk);
        check("t6_no_err", err_seen, exp_err);
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        wait_drain();
        check("t6_no_err_after", err_seen, exp_err);

        // 7: overflow with consumer stalled
        out_ready = 1'b0;
        exp_q.push_back({2'b00, 8'h15});
        exp_q.push_back({2'b00, 8'h1D});
        exp_q.push_back({2'b00, 8'h24});
        exp_q.push_back({2'b00, 8'h2D});
        send_frame(8'h15, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b1, 1'b0);
        send_frame(8'h24, 1'b0, 1'b1, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b1, 1'b0);
        send_frame(8'h2C, 1'b0, 1'b1, 1'b0);
        exp_ovf++;
        check("t7_overflow", ovf_seen, exp_ovf);
        check("t7_head_held", out_code, 8'h15);
        check("t7_no_frame_err", err_seen, exp_err);
        out_ready = 1'b1;
        wait_drain();

`ifdef PS2_RX_ERRCNT_EN
        check("errcnt_total", err_cnt, exp_err + exp_ovf);
`endif

        // 8: reset mid-frame, then a good frame
        send_partial(8'h5A, 4);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t8_rst_valid", out_valid, 0);
        check("t8_rst_code", out_code, 0);
`ifdef PS2_RX_ERRCNT_EN
        check("t8_rst_errcnt", err_cnt, 0);
`endif
        rst = 1'b1;
        repeat (HALF) @(negedge clk);
        exp_q.push_back({2'b00, 8'h5A});
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        wait_drain();
        check("t8_no_err", err_seen, exp_err);
        check("final_overflows", ovf_seen, exp_ovf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
